// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data-memory slave for the processor data port.
// Optional build macro DMEM_RAND_LAT_EN adds 0..3 LFSR-driven extra wait cycles per access.

module data_mem_responder_checker #(
  parameter int WORD_SIZE = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 waitreq,
  input logic [WORD_SIZE-1:0] data_in,
  input logic [1:0]           state
);

  // read data may only appear on a completion cycle, never while the processor is held
  a_quiet_while_waiting: assert property (@(posedge clk) disable iff (!rst_n)
    waitreq |-> (data_in == '0));

  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state != 2'd3);

endmodule

module data_mem_responder #(
  parameter int          WORD_SIZE = 16,
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 AccessErr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 5;
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef logic [WORD_SIZE:0] ext_t;
  localparam ext_t DEPTH_W = ext_t'(DEPTH);

  function automatic logic in_range(input logic [WORD_SIZE-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  logic [1:0]           state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic                 err_r, err_s;
  logic [WORD_SIZE-1:0] addr_r, wdata_r;
  logic                 rd_r, wr_r;
  logic [WORD_SIZE-1:0] mem_r [DEPTH];

  logic                 req_s;
  logic                 cap_s;
  logic                 wait_s;
  logic                 we_s;
  logic [AW-1:0]        waddr_s;
  logic [WORD_SIZE-1:0] wdata_s;
  logic [WORD_SIZE-1:0] rdata_s;
  logic [CW-1:0]        eff_lat_s;
  logic [CW-1:0]        lat_cur_s;

  assign req_s = ReadData | WriteData;

`ifdef DMEM_RAND_LAT_EN
  logic [15:0]   lfsr_r;
  logic [CW-1:0] lat_r;
  logic          lfsr_fb_s;

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign eff_lat_s = LAT_C + {3'b000, lfsr_r[1:0]};
  assign lat_cur_s = lat_r;

  // free-running LFSR; the effective latency is frozen when an access is captured
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr_r <= LFSR_SEED;
      lat_r  <= LAT_C;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
      if (state_r == IDLE && req_s) begin
        lat_r <= eff_lat_s;
      end else begin
        lat_r <= lat_r;
      end
    end
  end
`else
  logic unused_seed_s;

  assign unused_seed_s = ^LFSR_SEED;
  assign eff_lat_s     = LAT_C;
  assign lat_cur_s     = LAT_C;
`endif

  // access sequencing, completion decode and error detection
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    cap_s   = 1'b0;
    wait_s  = 1'b0;
    we_s    = 1'b0;
    waddr_s = '0;
    wdata_s = '0;
    rdata_s = '0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          err_s = err_r | (ReadData & WriteData);
          if (eff_lat_s == 5'd0) begin
            if (!in_range(DataAddr)) begin
              err_s = 1'b1;
            end else if (WriteData) begin
              we_s    = 1'b1;
              waddr_s = DataAddr[AW-1:0];
              wdata_s = DataOut;
            end else begin
              rdata_s = mem_r[DataAddr[AW-1:0]];
            end
          end else begin
            wait_s = 1'b1;
            cap_s  = 1'b1;
            cnt_s  = 5'd1;
            if (eff_lat_s == 5'd1) begin
              state_s = RESP;
            end else begin
              state_s = BUSY;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        wait_s = 1'b1;
        if (!req_s) begin
          state_s = IDLE;
          cnt_s   = 5'd0;
        end else begin
          cnt_s = cnt_r + 5'd1;
          if (cnt_s == lat_cur_s) begin
            state_s = RESP;
          end else begin
            state_s = BUSY;
          end
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = 5'd0;
        // the captured command executes regardless; a changed bus is only flagged
        if ((DataAddr != addr_r) || (ReadData != rd_r) || (WriteData != wr_r)) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (!in_range(addr_r)) begin
          err_s = 1'b1;
        end else if (wr_r) begin
          we_s    = 1'b1;
          waddr_s = addr_r[AW-1:0];
          wdata_s = wdata_r;
        end else begin
          rdata_s = mem_r[addr_r[AW-1:0]];
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 5'd0;
      end
    endcase
  end

  // state, wait counter and sticky error flag
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  // request capture at the start of a wait-stated access
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_r  <= '0;
      wdata_r <= '0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else if (cap_s) begin
      addr_r  <= DataAddr;
      wdata_r <= DataOut;
      rd_r    <= ReadData;
      wr_r    <= WriteData;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      rd_r    <= rd_r;
      wr_r    <= wr_r;
    end
  end

  // word array, cleared by reset
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end else begin
      mem_r[waddr_s] <= mem_r[waddr_s];
    end
  end

  assign DataWaitreq = wait_s & Resetn;
  assign DataIn      = Resetn ? rdata_s : '0;
  assign AccessErr   = err_r;

  data_mem_responder_checker #(
    .WORD_SIZE(WORD_SIZE)
  ) u_checker (
    .clk     (Clock),
    .rst_n   (Resetn),
    .waitreq (DataWaitreq),
    .data_in (DataIn),
    .state   (state_r)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a driver pushes expected completions,
// a monitor pops and compares them whenever the responder completes an access.
module tb_data_mem_responder;

  localparam int WS    = 16;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic [WS-1:0] DataAddr = '0;
  logic [WS-1:0] DataOut = '0;
  logic          ReadData = 1'b0;
  logic          WriteData = 1'b0;
  logic [WS-1:0] DataIn;
  logic          DataWaitreq;
  logic          AccessErr;

  data_mem_responder #(
    .WORD_SIZE(WS),
    .DEPTH(DEPTH),
    .LATENCY(LAT),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .DataAddr(DataAddr),
    .DataOut(DataOut),
    .ReadData(ReadData),
    .WriteData(WriteData),
    .DataIn(DataIn),
    .DataWaitreq(DataWaitreq),
    .AccessErr(AccessErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem [DEPTH];
  logic        model_err = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    foreach (model_mem[i]) model_mem[i] = 16'h0000;
    model_err = 1'b0;
  endtask

  // monitor: pops one expectation per completion cycle
  initial begin : monitor
    int   waits;
    logic pending;
    logic pend_err;
    exp_t e;
    waits = 0;
    pending = 1'b0;
    pend_err = 1'b0;
    forever begin
      @(negedge Clock);
      if (pending) begin
        check("err_after_access", {31'd0, AccessErr}, {31'd0, pend_err});
        check("idle_data_zero", {16'd0, DataIn}, 32'd0);
        pending = 1'b0;
      end
      if (!Resetn) begin
        waits = 0;
      end else if (ReadData || WriteData) begin
        if (DataWaitreq) begin
          waits++;
        end else begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("read_data", {16'd0, DataIn}, {16'd0, e.data});
`ifdef DMEM_RAND_LAT_EN
            check("wait_cycles_range", {31'd0, (waits >= LAT && waits <= LAT + 3)}, 32'd1);
`else
            check("wait_cycles", waits, LAT);
`endif
            pending = 1'b1;
            pend_err = e.err;
          end
          waits = 0;
        end
      end else begin
        waits = 0;
      end
    end
  end

  task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                        input logic [15:0] wd);
    exp_t e;
    logic ok;
    logic inr;
    ok  = 1'b0;
    inr = (int'(addr) < DEPTH);
    if (rd && wr) model_err = 1'b1;
    if (!inr) model_err = 1'b1;
    e.data = 16'h0000;
    if (wr) begin
      if (inr) model_mem[int'(addr)] = wd;
    end else if (inr) begin
      e.data = model_mem[int'(addr)];
    end
    e.err = model_err;
    exp_q.push_back(e);
    @(posedge Clock); #1;
    DataAddr = addr; DataOut = wd; ReadData = rd; WriteData = wr;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (!DataWaitreq) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no completion expected one for addr 0x%0h", addr);
    end
    @(posedge Clock); #1;
    ReadData = 1'b0; WriteData = 1'b0;
    DataAddr = 16'($urandom); DataOut = 16'($urandom);
  endtask

  task automatic abort_access(input logic [15:0] addr, input logic rd, input logic wr,
                              input logic [15:0] wd);
    @(posedge Clock); #1;
    DataAddr = addr; DataOut = wd; ReadData = rd; WriteData = wr;
    @(posedge Clock); #1;
    ReadData = 1'b0; WriteData = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("abort_idle_wait", {31'd0, DataWaitreq}, 32'd0);
    check("abort_idle_data", {16'd0, DataIn}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock); #1;
    Resetn = 1'b0; ReadData = 1'b0; WriteData = 1'b0;
    #1;
    check("rst_wait", {31'd0, DataWaitreq}, 32'd0);
    check("rst_data", {16'd0, DataIn}, 32'd0);
    check("rst_err", {31'd0, AccessErr}, 32'd0);
    repeat (2) @(posedge Clock);
    #2 Resetn = 1'b1;
    model_clear();
    @(negedge Clock);
    check("post_rst_wait", {31'd0, DataWaitreq}, 32'd0);
    check("post_rst_err", {31'd0, AccessErr}, 32'd0);
  endtask

  task automatic random_phase(input int n, input logic allow_bad);
    logic [15:0] a;
    int op;
    for (int i = 0; i < n; i++) begin
      if (allow_bad && $urandom_range(0, 5) == 0) a = 16'($urandom_range(256, 65535));
      else if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 255));
      else a = 16'($urandom_range(0, 15));
      op = $urandom_range(0, 19);
      if (op < 9) access(a, 1'b1, 1'b0, 16'($urandom));
      else if (op < 17) access(a, 1'b0, 1'b1, 16'($urandom));
      else if (op == 17 && allow_bad) access(a, 1'b1, 1'b1, 16'($urandom));
      else abort_access(a, op[0], ~op[0], 16'($urandom));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin : driver
    model_clear();
    do_reset();
    access(16'h0007, 1'b1, 1'b0, 16'h0000);
    access(16'h0010, 1'b0, 1'b1, 16'hBEEF);
    access(16'h0010, 1'b1, 1'b0, 16'h0000);
    abort_access(16'h0020, 1'b0, 1'b1, 16'h1234);
    access(16'h0020, 1'b1, 1'b0, 16'h0000);
    random_phase(120, 1'b0);
    access(16'h0100, 1'b1, 1'b0, 16'h0000);
    access(16'h0011, 1'b0, 1'b1, 16'hA5A5);
    access(16'h0011, 1'b1, 1'b0, 16'h0000);

    do_reset();
    access(16'h0005, 1'b1, 1'b1, 16'h00FF);
    access(16'h0005, 1'b1, 1'b0, 16'h0000);

    do_reset();
    access(16'h0010, 1'b0, 1'b1, 16'hBEEF);
    @(posedge Clock); #1;
    DataAddr = 16'h0030; DataOut = 16'h5555; WriteData = 1'b1; ReadData = 1'b0;
    @(posedge Clock); #2;
    Resetn = 1'b0;
    #1;
    check("rst_busy_wait", {31'd0, DataWaitreq}, 32'd0);
    check("rst_busy_data", {16'd0, DataIn}, 32'd0);
    WriteData = 1'b0;
    repeat (2) @(posedge Clock);
    #2 Resetn = 1'b1;
    model_clear();
    access(16'h0030, 1'b1, 1'b0, 16'h0000);
    access(16'h0010, 1'b1, 1'b0, 16'h0000);

    do_reset();
    random_phase(60, 1'b1);

    repeat (3) @(posedge Clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
